// File: rtl/sll32_if.sv
// Handshake bundle for the sequential left shifter: operand/shift-amount
// request channel and result/overflow response channel.
interface sll32_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res;
   logic             ovf;

   // Issue side drives operands and consumes the result.
   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, res, ovf
   );

   // Shifter side.
   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, res, ovf
   );
endinterface

// File: rtl/sll32_seq.sv
// Multi-cycle logical-left shifter. One shift-amount bit is resolved per
// cycle (log stages 1,2,4,8,16), so latency is fixed at SHAMT_W cycles
// regardless of the shift amount. A sticky flag records any 1-bit pushed
// out past the MSB.
module sll32_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic   clk,
   input  logic   rst_n,
   sll32_if.slave bus
);

   localparam int STG_W = 3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]         r_state;
   logic [WIDTH-1:0]   r_acc;
   logic [SHAMT_W-1:0] r_sh;
   logic [STG_W-1:0]   r_stg;
   logic               r_ovf_acc;
   logic [WIDTH-1:0]   r_res;
   logic               r_ovf;

   logic [SHAMT_W:0]   w_amt;
   logic [WIDTH-1:0]   w_shifted;
   logic [WIDTH-1:0]   w_lost;
   logic               w_take;
   logic               w_last;
   logic [WIDTH-1:0]   w_acc_nxt;
   logic               w_ovf_nxt;
   logic               w_accept;
   logic               w_deliver;

   // Handshake flags decode the state register only.
   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.res       = r_res;
   assign bus.ovf       = r_ovf;

   assign w_accept  = (r_state == S_IDLE) && bus.in_valid;
   assign w_deliver = (r_state == S_DONE) && bus.out_ready;
   assign w_last    = (r_stg == STG_W'(SHAMT_W - 1));

   // Current stage step: 1 << stg. The bits that fall off are the top
   // w_amt bits of the pre-shift accumulator.
   always_comb begin
      w_amt     = {{SHAMT_W{1'b0}}, 1'b1} << r_stg;
      w_take    = r_sh[r_stg];
      w_shifted = r_acc << w_amt;
      w_lost    = r_acc & ~({WIDTH{1'b1}} >> w_amt);
      w_acc_nxt = w_take ? w_shifted : r_acc;
      w_ovf_nxt = r_ovf_acc | (w_take & (|w_lost));
   end

   // Control FSM: accept in IDLE, fixed SHAMT_W stages, hold result in DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept)  r_state <= S_SHIFT;
            S_SHIFT: if (w_last)    r_state <= S_DONE;
            S_DONE:  if (w_deliver) r_state <= S_IDLE;
            default:                r_state <= S_IDLE;
         endcase
      end
   end

   // Stage counter: restarts on accept, walks 0..SHAMT_W-1 during SHIFT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stg <= '0;
      end else if (w_accept) begin
         r_stg <= '0;
      end else if (r_state == S_SHIFT) begin
         r_stg <= w_last ? '0 : r_stg + STG_W'(1);
      end
   end

   // Working accumulator and sticky shifted-out flag. Upper B bits are
   // intentionally dropped at capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc     <= '0;
         r_sh      <= '0;
         r_ovf_acc <= 1'b0;
      end else if (w_accept) begin
         r_acc     <= bus.A;
         r_sh      <= bus.B[SHAMT_W-1:0];
         r_ovf_acc <= 1'b0;
      end else if (r_state == S_SHIFT) begin
         r_acc     <= w_acc_nxt;
         r_ovf_acc <= w_ovf_nxt;
      end
   end

   // Output registers: loaded on the final stage so the previous result
   // stays visible through the next operation's IDLE and SHIFT phases.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res <= '0;
         r_ovf <= 1'b0;
      end else if ((r_state == S_SHIFT) && w_last) begin
         r_res <= w_acc_nxt;
         r_ovf <= w_ovf_nxt;
      end
   end

endmodule

// File: tb/tb_sll32_seq.sv
// Scoreboard bench for sll32_seq: drivers push expected results computed
// with plain 64-bit arithmetic; a monitor compares whenever out_valid is up.
module tb_sll32_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sll32_if #(.WIDTH(32)) bus ();

   sll32_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic        ovf;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   last_acc = 0;
   bit   rdy_rand = 1'b0;
   logic rdy_val  = 1'b1;
   logic prev_ov  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [63:0] w;
      w = {32'h0, a} << (b % 32);
      e.res = w[31:0];
      e.ovf = (w[63:32] != 32'h0);
      e.acc_cyc = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // out_ready driver: fixed value or random per cycle.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         bus.out_ready = rdy_rand ? 1'($urandom % 2) : rdy_val;
      end
   end

   // Monitor: compare the presented result against the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.out_valid) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_output res=%h ovf=%b", bus.res, bus.ovf);
               end else begin
                  chk("res", bus.res, sb[0].res);
                  chk("ovf", 32'(bus.ovf), 32'(sb[0].ovf));
                  chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                  if (!prev_ov) chk("latency", 32'(cyc - sb[0].acc_cyc), 32'd5);
                  if (bus.out_ready) void'(sb.pop_front());
               end
            end
         end
         prev_ov = bus.out_valid;
      end
   end

   // Present an operation and wait (bounded) for it to be accepted.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit keep);
      exp_t e;
      int   n = 0;
      bus.A = a;
      bus.B = b;
      bus.in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
         if (n > 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout a=%h b=%h", a, b);
            bus.in_valid = 1'b0;
            return;
         end
      end
      e = model(a, b);
      e.acc_cyc = cyc + 1;
      last_acc = cyc + 1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (!keep) bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      chk({tag, "_res"}, bus.res, 32'd0);
      chk({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
   endtask

   initial begin
      int acc_t[3];
      bus.in_valid = 1'b0;
      bus.A = '0;
      bus.B = '0;
      #1;
      reset_check("reset");
      #12;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases.
      issue(32'h000000A5, 32'd2, 1'b0);
      issue(32'h000000A5, 32'd1, 1'b0);
      issue(32'h80000001, 32'd1, 1'b0);
      issue(32'h00000001, 32'hFFFFFFE5, 1'b0);
      issue(32'h12345678, 32'd0, 1'b0);
      wait_drain();

      // Backpressure with input noise while the result is held.
      rdy_val = 1'b0;
      issue(32'hFFFFFFFF, 32'd31, 1'b0);
      begin
         int n = 0;
         while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (4) begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'($urandom % 2);
         bus.A = $urandom;
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_res_stable", bus.res, 32'h80000000);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      rdy_val = 1'b1;
      wait_drain();

      // Reset during the third SHIFT cycle aborts the operation.
      issue(32'h000000A5, 32'd3, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      reset_check("midreset");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(32'h00000001, 32'd4, 1'b0);
      wait_drain();

      // Back-to-back with in_valid and out_ready held high.
      for (int i = 0; i < 3; i++) begin
         issue($urandom, $urandom, 1'b1);
         acc_t[i] = last_acc;
      end
      bus.in_valid = 1'b0;
      chk("b2b_spacing_1", 32'(acc_t[1] - acc_t[0]), 32'd7);
      chk("b2b_spacing_2", 32'(acc_t[2] - acc_t[1]), 32'd7);
      wait_drain();

      // Randomized operands, shift amounts and output backpressure.
      rdy_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         a = (i % 5 == 0) ? 32'hFFFFFFFF : $urandom;
         b = (i % 2 == 0) ? $urandom : $urandom_range(0, 31);
         issue(a, b, 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      wait_drain();
      rdy_rand = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
